// File: rtl/shift_feed_fifo.sv
// Byte FIFO feeding the 8-bit shift-register stage: registered byte + 1-cycle enable
// strobe per byte, with an optional trailing run of pad bytes to drain the shifter.
module shift_feed_fifo #(
  parameter int          DEPTH     = 4,
  parameter int          PAD_LEN   = 8,
  parameter logic [7:0]  PAD_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [7:0]  io_in_bits,
  input  logic        io_hold,
  input  logic        io_flush,
  output logic [7:0]  io_out,
  output logic        io_enable,
  output logic        io_busy,
  output logic [15:0] io_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [1:0]    state_q, state_d;
  logic          pend_q, pend_d;
  logic [7:0]    pad_q, pad_d;
  logic [7:0]    out_q, out_d;
  logic          en_q, en_d;
  logic [15:0]   count_q, count_d;

  logic empty, full, push, issue_data, issue_pad;

  assign empty      = (occ_q == '0);
  assign full       = (occ_q == CW'(DEPTH));
  // Ready depends only on registered state so upstream can't form a comb loop through valid.
  assign io_in_ready = !reset && !full && !pend_q && (state_q != S_FLUSH);
  assign push       = io_in_valid && io_in_ready;
  assign issue_data = !io_hold && !empty && (state_q != S_FLUSH);
  assign issue_pad  = !io_hold && (state_q == S_FLUSH);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    state_d = state_q;
    pend_d  = pend_q;
    pad_d   = pad_q;
    out_d   = out_q;
    en_d    = 1'b0;
    count_d = count_q;

    if (push) tail_d = tail_q + 1'b1;
    occ_d = occ_q + CW'(push) - CW'(issue_data);

    if (issue_data) begin
      out_d   = mem_q[head_q];
      en_d    = 1'b1;
      head_d  = head_q + 1'b1;
      count_d = count_q + 16'd1;
    end

    if (state_q == S_FLUSH) begin
      if (issue_pad) begin
        out_d = PAD_VALUE;
        en_d  = 1'b1;
        pad_d = pad_q - 8'd1;
        if (pad_q == 8'd1) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
        end
      end
    end else if (pend_q && empty) begin
      state_d = S_FLUSH;
      pad_d   = 8'(PAD_LEN);
    end else begin
      if (io_flush && !pend_q) pend_d = 1'b1;
      state_d = (occ_d != '0) ? S_STREAM : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      pad_q   <= '0;
      out_q   <= '0;
      en_q    <= 1'b0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      pad_q   <= pad_d;
      out_q   <= out_d;
      en_q    <= en_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= io_in_bits;
  end

  assign io_out    = out_q;
  assign io_enable = en_q;
  assign io_count  = count_q;
  assign io_busy   = !reset && (!empty || pend_q || (state_q == S_FLUSH));
endmodule

// File: tb/tb_shift_feed_fifo.sv
// Scoreboard bench for shift_feed_fifo: queue-based reference model predicts every
// strobe (cycle, byte, count); a negedge monitor compares DUT outputs against it.
module tb_shift_feed_fifo;
  localparam int         DEPTH   = 4;
  localparam int         PAD_LEN = 8;
  localparam logic [7:0] PADV    = 8'h00;

  logic        clk = 0, reset = 1;
  logic        io_in_valid = 0, io_hold = 0, io_flush = 0;
  logic [7:0]  io_in_bits = 0;
  logic        io_in_ready, io_enable, io_busy;
  logic [7:0]  io_out;
  logic [15:0] io_count;

  shift_feed_fifo #(.DEPTH(DEPTH), .PAD_LEN(PAD_LEN), .PAD_VALUE(PADV)) dut (
    .clk(clk), .reset(reset), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits(io_in_bits), .io_hold(io_hold), .io_flush(io_flush), .io_out(io_out),
    .io_enable(io_enable), .io_busy(io_busy), .io_count(io_count));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic [15:0] c; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit chk_on = 0;

  // reference model state
  logic [7:0]  m_q[$];
  bit          m_pend = 0, m_flushing = 0;
  int          m_pads = 0;
  logic [15:0] m_count = 0;
  logic [7:0]  m_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++; n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Model: evaluated at each rising edge on the pre-edge inputs.
  initial forever begin
    bit rdy, do_push; int sz; logic [7:0] b;
    @(posedge clk);
    cyc++;
    rdy = !reset && (m_q.size() < DEPTH) && !m_pend && !m_flushing;
    if (reset) begin
      m_q.delete(); m_pend = 0; m_flushing = 0; m_pads = 0; m_count = 0; m_out = 0;
    end else begin
      sz = m_q.size(); do_push = io_in_valid && rdy; b = io_in_bits;
      if (m_flushing) begin
        if (!io_hold) begin
          m_out = PADV;
          exp_q.push_back('{PADV, m_count, cyc});
          m_pads--;
          if (m_pads == 0) begin m_flushing = 0; m_pend = 0; end
        end
      end else begin
        if (m_pend && sz == 0) begin m_flushing = 1; m_pads = PAD_LEN; end
        else if (io_flush && !m_pend) m_pend = 1;
        if (!io_hold && sz > 0) begin
          m_out = m_q.pop_front();
          m_count++;
          exp_q.push_back('{m_out, m_count, cyc});
        end
      end
      if (do_push) m_q.push_back(b);
    end
  end

  // Monitor: compares DUT against the scoreboard on the falling edge.
  initial forever begin
    bit exp_en; exp_t e;
    @(negedge clk);
    if (chk_on) begin
      exp_en = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("enable", io_enable, exp_en);
      if (exp_en) begin
        e = exp_q.pop_front();
        if (io_enable) begin
          chk("data", io_out, e.d);
          chk("count_at_issue", io_count, e.c);
        end
      end
      chk("out_held", io_out, m_out);
      chk("count", io_count, m_count);
      chk("ready", io_in_ready, !reset && (m_q.size() < DEPTH) && !m_pend && !m_flushing);
      chk("busy", io_busy, !reset && (m_q.size() > 0 || m_pend || m_flushing));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit r;
    io_in_valid = 1; io_in_bits = b;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); r = io_in_ready;
      step();
      if (r) return;
    end
    timeout("push");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!io_busy) begin step(); return; end
      step();
    end
    timeout("wait_idle");
  endtask

  task automatic wait_flushing();
    for (int k = 0; k < 50; k++) begin
      if (m_flushing) return;
      step();
    end
    timeout("wait_flushing");
  endtask

  task automatic post_reset_checks();
    @(negedge clk);
    chk("rst_enable", io_enable, 0);
    chk("rst_out", io_out, 0);
    chk("rst_count", io_count, 0);
    chk("rst_busy", io_busy, 0);
    chk("rst_ready", io_in_ready, 1);
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0; chk_on = 1;
    post_reset_checks();

    // consecutive pushes, no hold
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    io_in_valid = 0;
    wait_idle();
    chk("t1_count", io_count, 3);

    // fill while held, fifth byte stalls until hold released
    io_hold = 1;
    for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
    io_in_bits = 8'hA4;
    repeat (3) begin @(negedge clk); chk("t2_stall_ready", io_in_ready, 0); step(); end
    io_hold = 0;
    push_byte(8'hA4);
    io_in_valid = 0;
    wait_idle();
    chk("t2_count", io_count, 8);

    // flush on the same edge as the second push
    push_byte(8'h5A);
    io_flush = 1; push_byte(8'h5B); io_flush = 0;
    io_in_valid = 0;
    wait_idle();
    chk("t3_count", io_count, 10);

    // hold during flush plus an ignored second flush
    io_flush = 1; push_byte(8'h77); io_flush = 0;
    io_in_valid = 0;
    wait_flushing();
    step();
    io_hold = 1; io_flush = 1; step(); io_flush = 0; step(); step();
    io_hold = 0;
    wait_idle();
    chk("t4_count", io_count, 11);

    // reset with bytes buffered
    io_hold = 1;
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
    io_in_valid = 0;
    reset = 1; step(); reset = 0; io_hold = 0;
    post_reset_checks();
    repeat (4) step();

    // reset mid-flush
    io_flush = 1; push_byte(8'h44); io_flush = 0;
    io_in_valid = 0;
    wait_flushing();
    step(); step();
    reset = 1; step(); reset = 0;
    post_reset_checks();
    repeat (4) step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      io_in_valid = 1'($urandom_range(0, 1));
      io_in_bits  = 8'($urandom);
      io_hold     = ($urandom % 4) == 0;
      io_flush    = ($urandom % 40) == 0;
      reset       = ($urandom % 500) == 0;
      step();
    end
    io_in_valid = 0; io_hold = 0; io_flush = 0; reset = 0;
    wait_idle();

    // long stream: count wrap and pointer wrap
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 65537; i++) push_byte(i[7:0]);
    io_in_valid = 0;
    wait_idle();
    chk("t6_count_wrap", io_count, 16'h0001);

    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_feed_fifo.md
Name: shift_feed_fifo

Overview:
Upstream feeder for the 8-bit shift-register stage. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. It replays them as a registered byte stream with a one-cycle enable strobe: io_out/io_enable connect directly to the shift register's io_in/io_enable. On request it appends PAD_LEN pad bytes so the downstream shift register drains its contents.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
PAD_LEN, 8, pad bytes emitted per flush; 1..255
PAD_VALUE, 8'h00, byte value emitted during flush

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
io_in_valid  input  1  upstream byte valid
io_in_ready  output  1  block can accept a byte this cycle
io_in_bits  input  8  upstream byte
io_hold  input  1  downstream back-pressure; suppresses issue this cycle
io_flush  input  1  single-cycle flush request
io_out  output  8  byte to shift register (registered)
io_enable  output  1  io_out is new this cycle (registered, 1-cycle strobe per byte)
io_busy  output  1  FIFO non-empty, flush pending, or flushing
io_count  output  16  data bytes issued since reset, wraps at 2^16

Behaviour:
- Reset (reset=1 at a rising edge) clears the following:
  - FIFO pointers and occupancy
  - state to IDLE, flush_pending and pad counter
  - io_out=0, io_enable=0, io_count=0
- While reset is high, io_in_ready=0 and io_busy=0. Reset mid-flush or mid-stream discards all buffered bytes and pad progress.
- States: IDLE (FIFO empty, no flush pending), STREAM (FIFO non-empty), FLUSH (emitting pads).
- io_in_ready = !reset && occupancy<DEPTH && !flush_pending && state!=FLUSH. It is combinational from registered state only, never from io_in_valid.
- Push: occurs on a rising edge where io_in_valid && io_in_ready. io_in_bits is written at the tail pointer.
- Issue: on a rising edge with io_hold=0 and occupancy>0 (registered, pre-edge value) in IDLE/STREAM:
  - head byte → io_out, io_enable←1, head pointer and occupancy advance;
  - io_count increments.
- Otherwise io_enable←0 and io_out holds its last value.
- No bypass: a byte pushed at edge k is issued no earlier than edge k+1. It is therefore visible on io_out/io_enable in the cycle after edge k+1.
- Push and issue on the same edge are both allowed; occupancy is unchanged. At full, a same-edge issue does not make io_in_ready high in that cycle.
- Pointers wrap modulo DEPTH. Occupancy is tracked 0..DEPTH; full when occupancy=DEPTH, empty when 0.
- Flush:
  - io_flush=1 at an edge in IDLE/STREAM sets flush_pending.
  - Once the FIFO is empty (after the last data byte issues), the next edge enters FLUSH with pad counter=PAD_LEN.
  - In FLUSH, each edge with io_hold=0 issues PAD_VALUE with io_enable←1 and decrements the counter.
  - The issue that takes the counter to 0 returns the state to IDLE and clears flush_pending.
  - Pads never increment io_count.
  - io_flush while flush_pending or in FLUSH is ignored (no queuing, no restart).
  - io_flush on the same edge as a push: the push is still accepted, because ready was evaluated before the edge; that byte is issued before the pads.
- io_hold=1 pauses issue in any state. It does not block pushes; io_out is stable while held.
- io_busy = occupancy>0 || flush_pending || state==FLUSH.
- io_count: 16-bit increment, wraps 0xFFFF→0x0000.

Test Plan:
1. Reset then push 0x11,0x22,0x33 on consecutive edges with io_hold=0 → io_enable high for 3 consecutive cycles carrying 0x11,0x22,0x33, starting the cycle after the second edge; io_count=3; io_busy falls after the last issue.
2. io_hold=1, push 5 bytes 0xA0..0xA4 (DEPTH=4) → io_in_ready drops after 4 accepted; the 5th stalls. Release hold → A0..A3 then A4 issue in order, no loss or duplicate.
3. Push 0x5A,0x5B, pulse io_flush the same edge as the second push → 0x5A,0x5B issue, then exactly 8 cycles of io_out=0x00 with io_enable=1. io_in_ready=0 from the flush edge until FLUSH ends; io_count=2.
4. During FLUSH toggle io_hold 1 for 3 cycles and pulse io_flush again → 8 pads total, gaps exactly 3 cycles, second flush ignored.
5. Assert reset for 1 cycle with 3 bytes buffered and mid-flush → next cycle io_enable=0, io_out=0, io_count=0, io_busy=0, io_in_ready=1; no stale byte issues.
6. Stream 65537 bytes with io_hold=0 → io_count wraps to 0x0001; wrap-around of FIFO pointers preserves order (byte i = i mod 256 checked end-to-end).
